abies_audio_path: RTL and testbench

Parametrised per-channel sample router between the DDS, the I2S ADC receive path and the I2S DAC transmit path. It supersedes the fixed "DDS/8 to both DAC channels" wiring in the top level. It answers each transmit frame request with NCH samples, each independently sourced from DDS, ADC loopback, a DDS+ADC mix or mute, then attenuated by a per-channel arithmetic shift. ADC frames are buffered in a frame FIFO so that receive and transmit framing may drift.

---
 rtl/abies_audio_path_if.sv | 37 +++
 rtl/abies_audio_path.sv | 264 ++++++++++++++++++++++++++
 tb/tb_abies_audio_path.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/abies_audio_path_if.sv
// Stream bundle for abies_audio_path: transmit frame handshake, DDS advance/sample and ADC frame input.
// The master modport is the router's view; slave is the surrounding I2S/DDS logic.
interface abies_audio_path_if #(
    parameter int DW  = 24,
    parameter int NCH = 2
);
    logic                   tx_rd_en;
    logic                   tx_rd_valid;
    logic [NCH*DW-1:0]      tx_data;
    logic                   dds_ce;
    logic                   dds_valid;
    logic signed [DW-1:0]   dds_sample;
    logic                   rx_valid;
    logic [NCH*DW-1:0]      rx_data;

    modport master (
        input  tx_rd_en,
        output tx_rd_valid,
        output tx_data,
        output dds_ce,
        input  dds_valid,
        input  dds_sample,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        output tx_rd_en,
        input  tx_rd_valid,
        input  tx_data,
        input  dds_ce,
        output dds_valid,
        output dds_sample,
        output rx_valid,
        output rx_data
    );
endinterface

// File: rtl/abies_audio_path.sv
// Per-channel sample router: DDS / ADC loopback / saturated mix / mute, then arithmetic right shift.
// Define ABIES_PATH_STATUS_EN to add 16-bit saturating ovf/udf/miss event counters.
module abies_audio_path #(
    parameter int DW    = 24,
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int SW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    abies_audio_path_if.master      io,
    input  logic [NCH*2-1:0]        src_sel,
    input  logic [NCH*SW-1:0]       shift,
    input  logic                    status_clr,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    ovf_sticky,
    output logic                    udf_sticky,
    output logic                    miss_sticky
`ifdef ABIES_PATH_STATUS_EN
    ,
    output logic [15:0]             ovf_cnt,
    output logic [15:0]             udf_cnt,
    output logic [15:0]             miss_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = NCH * DW;

    localparam logic signed [DW:0] SAT_MAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] SAT_MIN = {2'b11, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_DDS, EMIT} state_t;

    // d + a in DW+1 bits, clamped back into the DW-bit signed range.
    function automatic logic signed [DW:0] sat_add(input logic signed [DW-1:0] d,
                                                   input logic signed [DW-1:0] a);
        logic signed [DW:0] s;
        s = {d[DW-1], d} + {a[DW-1], a};
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
        return s;
    endfunction

    // Arithmetic right shift with the amount clamped to DW-1 so large shifts settle at 0 or -1.
    function automatic logic signed [DW-1:0] shr_clamp(input logic signed [DW:0] v,
                                                       input logic [SW-1:0]      sh);
        logic signed [DW:0] r;
        int amt;
        amt = (int'(sh) > DW - 1) ? DW - 1 : int'(sh);
        r   = v >>> amt;
        return r[DW-1:0];
    endfunction

    function automatic logic signed [DW:0] chan_mix(input logic [1:0]           sel,
                                                    input logic signed [DW-1:0] d,
                                                    input logic signed [DW-1:0] a);
        logic signed [DW:0] v;
        case (sel)
            2'd1:    v = {d[DW-1], d};
            2'd2:    v = {a[DW-1], a};
            2'd3:    v = sat_add(d, a);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Source code bit 0 marks DDS use (1, 3); bit 1 marks ADC use (2, 3).
    function automatic logic uses_bit(input logic [NCH*2-1:0] s, input int b);
        logic r;
        r = 1'b0;
        for (int c = 0; c < NCH; c++)
            r = r | s[c*2 + b];
        return r;
    endfunction

`ifdef ABIES_PATH_STATUS_EN
    function automatic logic [15:0] cnt_next(input logic [15:0] c,
                                             input logic        set,
                                             input logic        clr);
        logic [15:0] n;
        n = c;
        if (clr)
            n = '0;
        else if (set && c != 16'hFFFF)
            n = c + 16'd1;
        return n;
    endfunction
`endif

    state_t              state_q,       state_d;
    logic [NCH*2-1:0]    src_q,         src_d;
    logic [NCH*SW-1:0]   shift_q,       shift_d;
    logic                dds_ce_q,      dds_ce_d;
    logic                tx_rd_valid_q, tx_rd_valid_d;
    logic [FW-1:0]       tx_data_q,     tx_data_d;

    logic [FW-1:0]       mem_q [DEPTH];
    logic [FW-1:0]       mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q,      wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q,      rd_ptr_d;
    logic [LW-1:0]       count_q,       count_d;

    logic                ovf_q,         ovf_d;
    logic                udf_q,         udf_d;
    logic                miss_q,        miss_d;

    logic                emit;
    logic                need_adc;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                ovf_set;
    logic                udf_set;
    logic                miss_set;
    logic [FW-1:0]       adc_frame;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LW'(DEPTH));
    assign need_adc   = uses_bit(src_q, 1);

    // Request sequencing. The emit work for a DDS request happens in the cycle dds_valid
    // arrives so the frame strobe lands one cycle after the sample.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        shift_d  = shift_q;
        dds_ce_d = 1'b0;
        emit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.tx_rd_en) begin
                    src_d   = src_sel;
                    shift_d = shift;
                    if (uses_bit(src_sel, 0)) begin
                        dds_ce_d = 1'b1;
                        state_d  = WAIT_DDS;
                    end else begin
                        state_d  = EMIT;
                    end
                end
            end
            WAIT_DDS: begin
                if (io.dds_valid) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                end
            end
            EMIT: begin
                emit    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        miss_set = io.tx_rd_en && (state_q != IDLE);
    end

    assign pop       = emit && need_adc && !fifo_empty;
    assign udf_set   = emit && need_adc && fifo_empty;
    assign adc_frame = pop ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        tx_rd_valid_d = emit;
        tx_data_d     = tx_data_q;
        if (emit) begin
            for (int c = 0; c < NCH; c++)
                tx_data_d[c*DW +: DW] = shr_clamp(
                    chan_mix(src_q[c*2 +: 2], io.dds_sample, adc_frame[c*DW +: DW]),
                    shift_q[c*SW +: SW]);
        end
    end

    // A full FIFO still accepts a push when the same cycle frees a slot.
    always_comb begin
        push    = io.rx_valid && (!fifo_full || pop);
        ovf_set = io.rx_valid && fifo_full && !pop;
        mem_d   = mem_q;
        if (push)
            mem_d[wr_ptr_q] = io.rx_data;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d  = status_clr ? 1'b0 : (ovf_q  | ovf_set);
        udf_d  = status_clr ? 1'b0 : (udf_q  | udf_set);
        miss_d = status_clr ? 1'b0 : (miss_q | miss_set);
    end

    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        src_q   <= src_d;
        shift_q <= shift_d;
        if (rst) begin
            state_q       <= IDLE;
            dds_ce_q      <= 1'b0;
            tx_rd_valid_q <= 1'b0;
            tx_data_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dds_ce_q      <= dds_ce_d;
            tx_rd_valid_q <= tx_rd_valid_d;
            tx_data_q     <= tx_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
            miss_q        <= miss_d;
        end
    end

`ifdef ABIES_PATH_STATUS_EN
    logic [15:0] ovf_cnt_q,  ovf_cnt_d;
    logic [15:0] udf_cnt_q,  udf_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        ovf_cnt_d  = cnt_next(ovf_cnt_q,  ovf_set,  status_clr);
        udf_cnt_d  = cnt_next(udf_cnt_q,  udf_set,  status_clr);
        miss_cnt_d = cnt_next(miss_cnt_q, miss_set, status_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q  <= '0;
            udf_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            ovf_cnt_q  <= ovf_cnt_d;
            udf_cnt_q  <= udf_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign ovf_cnt  = ovf_cnt_q;
    assign udf_cnt  = udf_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    assign io.tx_rd_valid = tx_rd_valid_q;
    assign io.tx_data     = tx_data_q;
    assign io.dds_ce      = dds_ce_q;
    assign fifo_level     = count_q;
    assign ovf_sticky     = ovf_q;
    assign udf_sticky     = udf_q;
    assign miss_sticky    = miss_q;

endmodule

// File: tb/tb_abies_audio_path.sv
// Scoreboard bench for abies_audio_path: expected frames are queued at request time and
// compared whenever tx_rd_valid strobes; scenario tasks also check timing and status inline.
module tb_abies_audio_path;
    localparam int DW    = 24;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int SW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    abies_audio_path_if #(.DW(DW), .NCH(NCH)) io ();

    logic [NCH*2-1:0]        src_sel;
    logic [NCH*SW-1:0]       shift;
    logic                    status_clr;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    ovf_sticky, udf_sticky, miss_sticky;
`ifdef ABIES_PATH_STATUS_EN
    logic [15:0]             ovf_cnt, udf_cnt, miss_cnt;
`endif

    abies_audio_path #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (io),
        .src_sel     (src_sel),
        .shift       (shift),
        .status_clr  (status_clr),
        .fifo_level  (fifo_level),
        .ovf_sticky  (ovf_sticky),
        .udf_sticky  (udf_sticky),
        .miss_sticky (miss_sticky)
`ifdef ABIES_PATH_STATUS_EN
        ,
        .ovf_cnt     (ovf_cnt),
        .udf_cnt     (udf_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int dds_ce_cnt = 0;
    logic [NCH*DW-1:0] sb_q [$];
    logic [NCH*DW-1:0] exp_frame;

    // Output monitor on the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (io.dds_ce) dds_ce_cnt++;
            if (io.tx_rd_valid) begin
                valid_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got tx_data=%h with no frame expected", io.tx_data);
                end else begin
                    exp_frame = sb_q.pop_front();
                    if (io.tx_data !== exp_frame) begin
                        errors++;
                        $display("FAIL tx_data: got %h want %h", io.tx_data, exp_frame);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*DW-1:0] frame(input int k);
        return {24'(32'hA00000 + k), 24'(32'h000100 + k)};
    endfunction

    task automatic check_reset_values(input string tag);
        checks++; if (io.tx_rd_valid !== 1'b0) begin errors++; $display("FAIL %s_tx_rd_valid: got %b want 0", tag, io.tx_rd_valid); end
        checks++; if (io.dds_ce !== 1'b0) begin errors++; $display("FAIL %s_dds_ce: got %b want 0", tag, io.dds_ce); end
        checks++; if (io.tx_data !== '0) begin errors++; $display("FAIL %s_tx_data: got %h want 0", tag, io.tx_data); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL %s_fifo_level: got %0d want 0", tag, fifo_level); end
        checks++; if ({ovf_sticky, udf_sticky, miss_sticky} !== 3'b000) begin errors++; $display("FAIL %s_sticky: got %b want 000", tag, {ovf_sticky, udf_sticky, miss_sticky}); end
    endtask

    task automatic test_reset();
        rst = 1'b1; status_clr = 1'b0; src_sel = '0; shift = '0;
        io.tx_rd_en = 1'b0; io.dds_valid = 1'b0; io.dds_sample = '0;
        io.rx_valid = 1'b0; io.rx_data = '0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_dds_path();
        int ce0, v0;
        ce0 = dds_ce_cnt; v0 = valid_cnt;
        src_sel = 4'b0101; shift = {5'd3, 5'd3};
        sb_q.push_back({24'h080000, 24'h080000});
        io.tx_rd_en = 1'b1; step(); io.tx_rd_en = 1'b0;
        checks++; if (io.dds_ce !== 1'b1) begin errors++; $display("FAIL dds_ce_pulse: got %b want 1", io.dds_ce); end
        step();
        checks++; if (io.dds_ce !== 1'b0) begin errors++; $display("FAIL dds_ce_single: got %b want 0", io.dds_ce); end
        checks++; if (io.tx_rd_valid !== 1'b0) begin errors++; $display("FAIL dds_early_valid: got %b want 0", io.tx_rd_valid); end
        step();
        io.dds_valid = 1'b1; io.dds_sample = 24'h400000; step(); io.dds_valid = 1'b0;
        checks++; if (io.tx_rd_valid !== 1'b1) begin errors++; $display("FAIL dds_latency: got %b want 1", io.tx_rd_valid); end
        step();
        checks++; if (dds_ce_cnt !== ce0 + 1) begin errors++; $display("FAIL dds_ce_count: got %0d want %0d", dds_ce_cnt, ce0 + 1); end
        checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL dds_valid_count: got %0d want %0d", valid_cnt, v0 + 1); end
    endtask

    task automatic test_adc_path();
        int ce0;
        ce0 = dds_ce_cnt;
        src_sel = 4'b0010; shift = '0;
        io.rx_data = {24'h7FFFFF, 24'h123456}; io.rx_valid = 1'b1; step(); io.rx_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL adc_level_push: got %0d want 1", fifo_level); end
        sb_q.push_back({24'h000000, 24'h123456});
        io.tx_rd_en = 1'b1; step(); io.tx_rd_en = 1'b0;
        checks++; if (io.tx_rd_valid !== 1'b0) begin errors++; $display("FAIL adc_early_valid: got %b want 0", io.tx_rd_valid); end
        step();
        checks++; if (io.tx_rd_valid !== 1'b1) begin errors++; $display("FAIL adc_latency: got %b want 1", io.tx_rd_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL adc_level_pop: got %0d want 0", fifo_level); end
        step();
        checks++; if (dds_ce_cnt !== ce0) begin errors++; $display("FAIL adc_no_dds_ce: got %0d want %0d", dds_ce_cnt, ce0); end
    endtask

    task automatic do_mix(input logic [DW-1:0] d, input logic [DW-1:0] a,
                          input logic [SW-1:0] sh, input logic [DW-1:0] expv, input string name);
        src_sel = 4'b1111; shift = {sh, sh};
        io.rx_data = {a, a}; io.rx_valid = 1'b1; step(); io.rx_valid = 1'b0;
        sb_q.push_back({expv, expv});
        io.tx_rd_en = 1'b1; step(); io.tx_rd_en = 1'b0;
        step();
        io.dds_valid = 1'b1; io.dds_sample = d; step(); io.dds_valid = 1'b0;
        checks++; if (io.tx_rd_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, io.tx_rd_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL %s_level: got %0d want 0", name, fifo_level); end
        step();
    endtask

    task automatic test_mix();
        do_mix(24'h700000, 24'h200000, 5'd0,  24'h7FFFFF, "mix_sat_pos");
        do_mix(24'h900000, 24'h900000, 5'd0,  24'h800000, "mix_sat_neg");
        do_mix(24'h900000, 24'h000000, 5'd31, 24'hFFFFFF, "mix_shift_max");
        do_mix(24'h400000, 24'hF00000, 5'd4,  24'h030000, "mix_shift4");
    endtask

    task automatic test_underflow();
        src_sel = 4'b1010; shift = '0;
        sb_q.push_back('0);
        io.tx_rd_en = 1'b1; step(); io.tx_rd_en = 1'b0; step();
        checks++; if (io.tx_rd_valid !== 1'b1) begin errors++; $display("FAIL udf_valid: got %b want 1", io.tx_rd_valid); end
        checks++; if (udf_sticky !== 1'b1) begin errors++; $display("FAIL udf_set: got %b want 1", udf_sticky); end
`ifdef ABIES_PATH_STATUS_EN
        checks++; if (udf_cnt !== 16'd1) begin errors++; $display("FAIL udf_cnt: got %0d want 1", udf_cnt); end
`endif
        status_clr = 1'b1; step(); status_clr = 1'b0;
        checks++; if (udf_sticky !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b want 0", udf_sticky); end
        sb_q.push_back('0);
        io.tx_rd_en = 1'b1; step(); io.tx_rd_en = 1'b0;
        status_clr = 1'b1; step(); status_clr = 1'b0;
        checks++; if (io.tx_rd_valid !== 1'b1) begin errors++; $display("FAIL udf_clr_valid: got %b want 1", io.tx_rd_valid); end
        checks++; if (udf_sticky !== 1'b0) begin errors++; $display("FAIL udf_clear_priority: got %b want 0", udf_sticky); end
        step();
    endtask

    task automatic test_overflow();
        int order [4] = '{1, 2, 3, 5};
        src_sel = 4'b1010; shift = '0;
        for (int k = 0; k < 5; k++) begin
            io.rx_data = frame(k); io.rx_valid = 1'b1; step();
        end
        io.rx_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_sticky); end
`ifdef ABIES_PATH_STATUS_EN
        checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt: got %0d want 1", ovf_cnt); end
`endif
        status_clr = 1'b1; step(); status_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf_sticky); end
        sb_q.push_back(frame(0));
        io.tx_rd_en = 1'b1; step(); io.tx_rd_en = 1'b0;
        io.rx_data = frame(5); io.rx_valid = 1'b1; step(); io.rx_valid = 1'b0;
        checks++; if (io.tx_rd_valid !== 1'b1) begin errors++; $display("FAIL full_pushpop_valid: got %b want 1", io.tx_rd_valid); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_pushpop_level: got %0d want 4", fifo_level); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b want 0", ovf_sticky); end
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(frame(order[i]));
            io.tx_rd_en = 1'b1; step(); io.tx_rd_en = 1'b0; step();
            checks++; if (io.tx_rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d: got %b want 1", i, io.tx_rd_valid); end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", fifo_level); end
        step();
    endtask

    task automatic test_miss_and_reset();
        int ce0, v0;
        src_sel = 4'b0101; shift = '0;
        ce0 = dds_ce_cnt; v0 = valid_cnt;
        io.tx_rd_en = 1'b1; step(); step(); io.tx_rd_en = 1'b0;
        checks++; if (miss_sticky !== 1'b1) begin errors++; $display("FAIL miss_set: got %b want 1", miss_sticky); end
        checks++; if (io.dds_ce !== 1'b0) begin errors++; $display("FAIL miss_no_ce: got %b want 0", io.dds_ce); end
        checks++; if (dds_ce_cnt !== ce0 + 1) begin errors++; $display("FAIL miss_ce_count: got %0d want %0d", dds_ce_cnt, ce0 + 1); end
        rst = 1'b1; step(); rst = 1'b0;
        check_reset_values("midreset");
        io.dds_valid = 1'b1; io.dds_sample = 24'h123456; step(); io.dds_valid = 1'b0;
        step(); step();
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL late_dds_ignored: got %0d strobes want %0d", valid_cnt, v0); end
        checks++; if (io.tx_rd_valid !== 1'b0) begin errors++; $display("FAIL late_dds_valid: got %b want 0", io.tx_rd_valid); end
    endtask

    initial begin
        test_reset();
        test_dds_path();
        test_adc_path();
        test_mix();
        test_underflow();
        test_overflow();
        test_miss_and_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d frames outstanding want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
